// File: rtl/weight_load_arbiter.sv
// weight_load_arbiter
// Shared weight-memory front end. NUM_CH networks post load requests, each
// with a beat count. Pending requests are served round-robin: the granted
// channel's beats are read one at a time from the single weight memory and
// handed to that channel through a one-entry valid/ready output register.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ch_load         per-channel load request pulse
//   ch_beats        per-channel beat count, sampled with ch_load
//   ch_weights_vld  beat valid towards the owning channel (one-hot or zero)
//   ch_weights_rdy  per-channel consumer ready
//   ch_weight_data  shared beat data bus
//   ch_last         current output beat is the final beat of its load
//   ch_done         one-cycle pulse after the final beat was accepted
//   mem_req         read request for (mem_ch, mem_beat)
//   mem_ch          channel being serviced
//   mem_beat        beat index within the current load
//   mem_ready       memory returns mem_data this cycle
//   mem_data        beat data from memory
module weight_load_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int BEAT_WORDS = 8,
  parameter int WORD_W     = 64,
  parameter int BEAT_CNT_W = 8,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_CH-1:0]                     ch_load,
  input  logic [NUM_CH-1:0][BEAT_CNT_W-1:0]     ch_beats,
  output logic [NUM_CH-1:0]                     ch_weights_vld,
  input  logic [NUM_CH-1:0]                     ch_weights_rdy,
  output logic [BEAT_WORDS-1:0][WORD_W-1:0]     ch_weight_data,
  output logic                                  ch_last,
  output logic [NUM_CH-1:0]                     ch_done,
  output logic                                  mem_req,
  output logic [CH_W-1:0]                       mem_ch,
  output logic [BEAT_CNT_W-1:0]                 mem_beat,
  input  logic                                  mem_ready,
  input  logic [BEAT_WORDS-1:0][WORD_W-1:0]     mem_data
);

  typedef enum logic [1:0] {IDLE, GRANT, REQ, DRAIN} state_t;

  state_t                               state, state_nxt;
  logic [NUM_CH-1:0]                    pending;
  logic [NUM_CH-1:0][BEAT_CNT_W-1:0]    beats_q;
  logic [CH_W-1:0]                      rr_ptr;
  logic [CH_W-1:0]                      rr_pick;
  logic [CH_W-1:0]                      grant;
  logic [BEAT_CNT_W-1:0]                beat_idx;
  logic [BEAT_CNT_W-1:0]                out_idx;
  logic [BEAT_CNT_W-1:0]                last_idx;
  logic                                 out_vld;
  logic [BEAT_WORDS-1:0][WORD_W-1:0]    out_data;
  logic [NUM_CH-1:0]                    done_q;
  logic [NUM_CH-1:0]                    active;
  logic [NUM_CH-1:0]                    accept_load;
  logic                                 out_accept;
  logic                                 capture;
  logic                                 last_capture;

  // A channel only counts as active once its grant is latched (REQ/DRAIN);
  // during GRANT the grant register still holds the previous owner, and the
  // channel about to be served is still protected by its pending bit.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      active[i]         = ((state == REQ) || (state == DRAIN)) && (grant == CH_W'(i));
      accept_load[i]    = ch_load[i] && (ch_beats[i] != '0) && !pending[i] && !active[i];
      ch_weights_vld[i] = out_vld && (grant == CH_W'(i));
    end
  end

  // Round-robin pick: scan downwards so the pending channel closest to
  // rr_ptr (wrapping) is the one that sticks.
  always_comb begin
    rr_pick = rr_ptr;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (pending[(int'(rr_ptr) + k) % NUM_CH]) begin
        rr_pick = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      end
    end
  end

  // Memory is only asked for a beat when the output register has room,
  // either because it is empty or because it is drained this same cycle.
  always_comb begin
    last_idx     = beats_q[grant] - BEAT_CNT_W'(1);
    out_accept   = out_vld && ch_weights_rdy[grant];
    mem_req      = (state == REQ) && (!out_vld || ch_weights_rdy[grant]);
    capture      = mem_req && mem_ready;
    last_capture = capture && (beat_idx == last_idx);
  end

  // Leaving IDLE also considers loads arriving this cycle, so a request seen
  // at cycle t is granted at t+1 and reaches memory at t+2.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if ((|pending) || (|accept_load)) state_nxt = GRANT;
      GRANT:   state_nxt = REQ;
      REQ:     if (last_capture) state_nxt = DRAIN;
      DRAIN:   if (out_accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, request bookkeeping and the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= '0;
      beats_q  <= '0;
      rr_ptr   <= '0;
      grant    <= '0;
      beat_idx <= '0;
      out_idx  <= '0;
      out_vld  <= 1'b0;
      out_data <= '0;
      done_q   <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= '0;

      for (int i = 0; i < NUM_CH; i++) begin
        if (accept_load[i]) begin
          pending[i] <= 1'b1;
          beats_q[i] <= ch_beats[i];
        end
      end

      if (state == GRANT) begin
        grant            <= rr_pick;
        pending[rr_pick] <= 1'b0;
        rr_ptr           <= (int'(rr_pick) == NUM_CH - 1) ? '0 : rr_pick + CH_W'(1);
        beat_idx         <= '0;
      end

      // A capture while the old beat is being accepted simply overwrites it.
      if (capture) begin
        out_data <= mem_data;
        out_idx  <= beat_idx;
        out_vld  <= 1'b1;
        beat_idx <= beat_idx + BEAT_CNT_W'(1);
      end else if (out_accept) begin
        out_vld <= 1'b0;
      end

      if ((state == DRAIN) && out_accept) begin
        done_q[grant] <= 1'b1;
      end
    end
  end

  assign ch_weight_data = out_data;
  assign ch_last        = out_vld && (out_idx == last_idx);
  assign ch_done        = done_q;
  assign mem_ch         = grant;
  assign mem_beat       = beat_idx;

endmodule

// File: tb/tb_weight_load_arbiter.sv
// tb_weight_load_arbiter
// Directed bench for weight_load_arbiter with NUM_CH=2. A memory model
// returns a beat pattern derived from (channel, beat). Per-cycle vectors hold
// the inputs for one cycle and the outputs expected in that cycle; reset
// mid-load and the load following it are driven by hand.
module tb_weight_load_arbiter;

  localparam int NUM_CH     = 2;
  localparam int BEAT_WORDS = 8;
  localparam int WORD_W     = 64;
  localparam int BEAT_CNT_W = 8;
  localparam int CH_W       = 1;

  typedef logic [BEAT_WORDS-1:0][WORD_W-1:0] beat_t;

  typedef struct {
    string      label;
    logic [1:0] load;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [1:0] rdy;
    logic       mr;
    logic       exp_req;
    logic       exp_ch;
    logic [7:0] exp_beat;
    logic [1:0] exp_vld;
    logic       exp_last;
    logic [1:0] exp_done;
    logic [7:0] exp_didx;
  } vec_t;

  logic                                 clk;
  logic                                 rst;
  logic [NUM_CH-1:0]                    ch_load;
  logic [NUM_CH-1:0][BEAT_CNT_W-1:0]    ch_beats;
  logic [NUM_CH-1:0]                    ch_weights_vld;
  logic [NUM_CH-1:0]                    ch_weights_rdy;
  beat_t                                ch_weight_data;
  logic                                 ch_last;
  logic [NUM_CH-1:0]                    ch_done;
  logic                                 mem_req;
  logic [CH_W-1:0]                      mem_ch;
  logic [BEAT_CNT_W-1:0]                mem_beat;
  logic                                 mem_ready;
  beat_t                                mem_data;

  int   n_vectors;
  int   n_miscompares;
  vec_t vecs[$];

  weight_load_arbiter #(
    .NUM_CH(NUM_CH), .BEAT_WORDS(BEAT_WORDS), .WORD_W(WORD_W),
    .BEAT_CNT_W(BEAT_CNT_W), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst(rst),
    .ch_load(ch_load), .ch_beats(ch_beats),
    .ch_weights_vld(ch_weights_vld), .ch_weights_rdy(ch_weights_rdy),
    .ch_weight_data(ch_weight_data), .ch_last(ch_last), .ch_done(ch_done),
    .mem_req(mem_req), .mem_ch(mem_ch), .mem_beat(mem_beat),
    .mem_ready(mem_ready), .mem_data(mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat contents identify channel, beat index and word position.
  function automatic beat_t pat(input int ch, input int beat);
    beat_t b;
    for (int w = 0; w < BEAT_WORDS; w++) begin
      b[w] = {8'hA5, 8'(ch), 8'(beat), 8'(w), 32'hC0DE_0000 | 32'(w)};
    end
    return b;
  endfunction

  assign mem_data = pat(int'(mem_ch), int'(mem_beat));

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic addVec(input string label, input logic [1:0] load, input int b0, input int b1,
                        input logic [1:0] rdy, input logic mr, input logic req, input logic ch,
                        input int beat, input logic [1:0] vld, input logic last,
                        input logic [1:0] done, input int didx);
    vec_t v;
    v.label = label; v.load = load; v.b0 = 8'(b0); v.b1 = 8'(b1); v.rdy = rdy; v.mr = mr;
    v.exp_req = req; v.exp_ch = ch; v.exp_beat = 8'(beat); v.exp_vld = vld;
    v.exp_last = last; v.exp_done = done; v.exp_didx = 8'(didx);
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs after the falling edge, then compare the
  // settled outputs of that cycle before the next rising edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    logic [14:0] act_ctl, exp_ctl;
    @(negedge clk);
    ch_load        = v.load;
    ch_beats       = {v.b1, v.b0};
    ch_weights_rdy = v.rdy;
    mem_ready      = v.mr;
    #1;
    act_ctl = {mem_req, mem_req ? mem_ch : 1'b0, mem_req ? mem_beat : 8'd0,
               ch_weights_vld, ch_last, ch_done};
    exp_ctl = {v.exp_req, v.exp_req ? v.exp_ch : 1'b0, v.exp_req ? v.exp_beat : 8'd0,
               v.exp_vld, v.exp_last, v.exp_done};
    checkOutput($sformatf("%s[%0d] ctl", v.label, idx), 512'(act_ctl), 512'(exp_ctl));
    if (v.exp_vld != 2'b00) begin
      checkOutput($sformatf("%s[%0d] data", v.label, idx), 512'(ch_weight_data),
                  512'(pat(v.exp_vld[1] ? 1 : 0, int'(v.exp_didx))));
    end
  endtask

  initial begin
    int  got;
    bit  found;
    bit  done_seen;
    bit  first_req;

    n_vectors      = 0;
    n_miscompares  = 0;
    rst            = 1'b1;
    ch_load        = '0;
    ch_beats       = '0;
    ch_weights_rdy = 2'b11;
    mem_ready      = 1'b1;

    // label, load, b0, b1, rdy, mr | req, ch, beat, vld, last, done, didx
    addVec("idle",   0, 0, 0, 3, 1,  0, 0, 0, 0, 0, 0, 0);
    // single load on channel 1, three beats
    addVec("single", 2, 0, 3, 3, 1,  0, 0, 0, 0, 0, 0, 0);
    addVec("single", 0, 0, 0, 3, 1,  0, 0, 0, 0, 0, 0, 0);
    addVec("single", 0, 0, 0, 3, 1,  1, 1, 0, 0, 0, 0, 0);
    addVec("single", 0, 0, 0, 3, 1,  1, 1, 1, 2, 0, 0, 0);
    addVec("single", 0, 0, 0, 3, 1,  1, 1, 2, 2, 0, 0, 1);
    addVec("single", 0, 0, 0, 3, 1,  0, 0, 0, 2, 1, 0, 2);
    addVec("single", 0, 0, 0, 3, 1,  0, 0, 0, 0, 0, 2, 0);
    addVec("single", 0, 0, 0, 3, 1,  0, 0, 0, 0, 0, 0, 0);
    // both channels together, pointer at 0: channel 0 first
    addVec("rr",     3, 2, 2, 3, 1,  0, 0, 0, 0, 0, 0, 0);
    addVec("rr",     0, 0, 0, 3, 1,  0, 0, 0, 0, 0, 0, 0);
    addVec("rr",     0, 0, 0, 3, 1,  1, 0, 0, 0, 0, 0, 0);
    addVec("rr",     0, 0, 0, 3, 1,  1, 0, 1, 1, 0, 0, 0);
    addVec("rr",     0, 0, 0, 3, 1,  0, 0, 0, 1, 1, 0, 1);
    addVec("rr",     0, 0, 0, 3, 1,  0, 0, 0, 0, 0, 1, 0);
    addVec("rr",     0, 0, 0, 3, 1,  0, 0, 0, 0, 0, 0, 0);
    addVec("rr",     0, 0, 0, 3, 1,  1, 1, 0, 0, 0, 0, 0);
    addVec("rr",     0, 0, 0, 3, 1,  1, 1, 1, 2, 0, 0, 0);
    addVec("rr",     0, 0, 0, 3, 1,  0, 0, 0, 2, 1, 0, 1);
    addVec("rr",     0, 0, 0, 3, 1,  0, 0, 0, 0, 0, 2, 0);
    // channel 0 alone moves the pointer to 1; a pair posted on its done
    // cycle is accepted and channel 1 now wins
    addVec("rr2",    1, 1, 0, 3, 1,  0, 0, 0, 0, 0, 0, 0);
    addVec("rr2",    0, 0, 0, 3, 1,  0, 0, 0, 0, 0, 0, 0);
    addVec("rr2",    0, 0, 0, 3, 1,  1, 0, 0, 0, 0, 0, 0);
    addVec("rr2",    0, 0, 0, 3, 1,  0, 0, 0, 1, 1, 0, 0);
    addVec("rr2",    3, 1, 1, 3, 1,  0, 0, 0, 0, 0, 1, 0);
    addVec("rr2",    0, 0, 0, 3, 1,  0, 0, 0, 0, 0, 0, 0);
    addVec("rr2",    0, 0, 0, 3, 1,  1, 1, 0, 0, 0, 0, 0);
    addVec("rr2",    0, 0, 0, 3, 1,  0, 0, 0, 2, 1, 0, 0);
    addVec("rr2",    0, 0, 0, 3, 1,  0, 0, 0, 0, 0, 2, 0);
    addVec("rr2",    0, 0, 0, 3, 1,  0, 0, 0, 0, 0, 0, 0);
    addVec("rr2",    0, 0, 0, 3, 1,  1, 0, 0, 0, 0, 0, 0);
    addVec("rr2",    0, 0, 0, 3, 1,  0, 0, 0, 1, 1, 0, 0);
    addVec("rr2",    0, 0, 0, 3, 1,  0, 0, 0, 0, 0, 1, 0);
    addVec("rr2",    0, 0, 0, 3, 1,  0, 0, 0, 0, 0, 0, 0);
    // backpressure: channel 0 not ready for five cycles after beat 0
    addVec("bp",     1, 4, 0, 3, 1,  0, 0, 0, 0, 0, 0, 0);
    addVec("bp",     0, 0, 0, 3, 1,  0, 0, 0, 0, 0, 0, 0);
    addVec("bp",     0, 0, 0, 3, 1,  1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) addVec("bp", 0, 0, 0, 2, 1,  0, 0, 0, 1, 0, 0, 0);
    addVec("bp",     0, 0, 0, 3, 1,  1, 0, 1, 1, 0, 0, 0);
    addVec("bp",     0, 0, 0, 3, 1,  1, 0, 2, 1, 0, 0, 1);
    addVec("bp",     0, 0, 0, 3, 1,  1, 0, 3, 1, 0, 0, 2);
    addVec("bp",     0, 0, 0, 3, 1,  0, 0, 0, 1, 1, 0, 3);
    addVec("bp",     0, 0, 0, 3, 1,  0, 0, 0, 0, 0, 1, 0);
    // memory stall: mem_ready alternating
    addVec("stall",  2, 0, 3, 3, 1,  0, 0, 0, 0, 0, 0, 0);
    addVec("stall",  0, 0, 0, 3, 0,  0, 0, 0, 0, 0, 0, 0);
    addVec("stall",  0, 0, 0, 3, 1,  1, 1, 0, 0, 0, 0, 0);
    addVec("stall",  0, 0, 0, 3, 0,  1, 1, 1, 2, 0, 0, 0);
    addVec("stall",  0, 0, 0, 3, 1,  1, 1, 1, 0, 0, 0, 0);
    addVec("stall",  0, 0, 0, 3, 0,  1, 1, 2, 2, 0, 0, 1);
    addVec("stall",  0, 0, 0, 3, 1,  1, 1, 2, 0, 0, 0, 0);
    addVec("stall",  0, 0, 0, 3, 0,  0, 0, 0, 2, 1, 0, 2);
    addVec("stall",  0, 0, 0, 3, 1,  0, 0, 0, 0, 0, 2, 0);
    // drop rules: zero-beat load, reloads while pending and while active
    addVec("drop",   1, 0, 0, 3, 1,  0, 0, 0, 0, 0, 0, 0);
    addVec("drop",   0, 0, 0, 3, 1,  0, 0, 0, 0, 0, 0, 0);
    addVec("drop",   0, 0, 0, 3, 1,  0, 0, 0, 0, 0, 0, 0);
    addVec("drop",   1, 2, 0, 3, 1,  0, 0, 0, 0, 0, 0, 0);
    addVec("drop",   1, 9, 0, 3, 1,  0, 0, 0, 0, 0, 0, 0);
    addVec("drop",   1, 5, 0, 3, 1,  1, 0, 0, 0, 0, 0, 0);
    addVec("drop",   1, 7, 0, 3, 1,  1, 0, 1, 1, 0, 0, 0);
    addVec("drop",   0, 0, 0, 3, 1,  0, 0, 0, 1, 1, 0, 1);
    addVec("drop",   0, 0, 0, 3, 1,  0, 0, 0, 0, 0, 1, 0);
    addVec("drop",   0, 0, 0, 3, 1,  0, 0, 0, 0, 0, 0, 0);
    addVec("drop",   0, 0, 0, 3, 1,  0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset state",
                512'({ch_weights_vld, ch_last, ch_done, mem_req, mem_ch, mem_beat}), 512'(0));
    checkOutput("reset data", 512'(ch_weight_data), 512'(0));
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    // Reset in the middle of a five-beat load on channel 0.
    @(negedge clk);
    ch_load  = 2'b01;
    ch_beats = {8'd0, 8'd5};
    found    = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      ch_load = '0;
      #1;
      if (mem_req && mem_beat == 8'd2) found = 1'b1;
    end
    checkOutput("reach beat 2", 512'(found), 512'(1));
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("mid-load reset ctl",
                512'({ch_weights_vld, ch_last, ch_done, mem_req, mem_ch, mem_beat}), 512'(0));
    checkOutput("mid-load reset data", 512'(ch_weight_data), 512'(0));
    rst = 1'b0;

    // A fresh two-beat load on channel 1 must run from beat 0 to ch_done.
    @(negedge clk);
    ch_load   = 2'b10;
    ch_beats  = {8'd2, 8'd0};
    got       = 0;
    done_seen = 1'b0;
    first_req = 1'b0;
    for (int c = 0; c < 20 && !done_seen; c++) begin
      @(negedge clk);
      ch_load = '0;
      #1;
      if (mem_req && !first_req) begin
        first_req = 1'b1;
        checkOutput("post-reset first req", 512'({mem_ch, mem_beat}), 512'({1'b1, 8'd0}));
      end
      if (ch_weights_vld == 2'b10) begin
        checkOutput($sformatf("post-reset beat %0d data", got), 512'(ch_weight_data),
                    512'(pat(1, got)));
        checkOutput($sformatf("post-reset beat %0d last", got), 512'(ch_last),
                    512'(got == 1));
        got++;
      end
      if (ch_done == 2'b10) done_seen = 1'b1;
    end
    checkOutput("post-reset completion", 512'({done_seen, 8'(got)}), 512'({1'b1, 8'd2}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
